// File: rtl/dma_chan_arbiter_if.sv
// Request/grant and DMA start/done signals shared between the channel arbiter and its surroundings.
// The slave modport is the arbiter's view of these signals.
interface dma_chan_arbiter_if #(
  parameter int NCH = 4,
  parameter int IDW = 2
);
  logic [NCH-1:0] req;
  logic [NCH-1:0] ch_mask;
  logic           dma_done;
  logic [NCH-1:0] gnt;
  logic [IDW-1:0] ch_id;
  logic           dma_start;
  logic           busy;
  logic           timeout;

  modport slave (
    input  req, ch_mask, dma_done,
    output gnt, ch_id, dma_start, busy, timeout
  );

  modport master (
    output req, ch_mask, dma_done,
    input  gnt, ch_id, dma_start, busy, timeout
  );
endinterface

// File: rtl/dma_chan_arbiter.sv
// Round-robin arbiter that hands the single DMA engine to one of NCH channels at a time.
// It holds the grant until the engine reports done or the watchdog expires.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | engine free, arbitrating among eligible requesters
// S_START   | grant registered, issuing the one-cycle dma_start pulse
// S_BUSY    | engine running, waiting for dma_done or watchdog expiry
// S_RELEASE | dropping grant/busy, advancing the round-robin pointer
module dma_chan_arbiter #(
  parameter int NCH     = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  dma_chan_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_BUSY    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [TW-1:0]  WDOG_LOAD = TW'(TIMEOUT);
  localparam logic [TW-1:0]  WDOG_ONE  = TW'(1);
  localparam bit             WDOG_EN   = (TIMEOUT != 0);
  localparam logic [IDW-1:0] PTR_RST   = IDW'(NCH - 1);
  localparam logic [NCH-1:0] GNT_ONE   = NCH'(1);

  state_t         r_state;
  logic [NCH-1:0] r_gnt;
  logic [IDW-1:0] r_ch_id;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_dma_start;
  logic           r_busy;
  logic           r_timeout;
  logic [TW-1:0]  r_wdog;

  logic [NCH-1:0] w_elig;
  logic           w_found;
  logic [IDW-1:0] w_sel;
  logic [IDW-1:0] w_idx;

  assign w_elig = bus.req & ~bus.ch_mask;

  // Search starts just after the last-granted channel so it gets lowest priority next time.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int i = 1; i <= NCH; i++) begin
      w_idx = IDW'((int'(r_rr_ptr) + i) % NCH);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_gnt       <= '0;
      r_ch_id     <= '0;
      r_rr_ptr    <= PTR_RST;
      r_dma_start <= 1'b0;
      r_busy      <= 1'b0;
      r_timeout   <= 1'b0;
      r_wdog      <= '0;
    end else begin
      r_dma_start <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= GNT_ONE << w_sel;
            r_ch_id <= w_sel;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          r_dma_start <= 1'b1;
          r_wdog      <= WDOG_LOAD;
          r_state     <= S_BUSY;
        end
        S_BUSY: begin
          // A done on the expiry cycle wins, so no timeout is reported for it.
          if (bus.dma_done) begin
            r_state <= S_RELEASE;
          end else if (WDOG_EN && (r_wdog == WDOG_ONE)) begin
            r_timeout <= 1'b1;
            r_state   <= S_RELEASE;
          end else if (WDOG_EN) begin
            r_wdog <= r_wdog - WDOG_ONE;
          end
        end
        S_RELEASE: begin
          r_gnt    <= '0;
          r_busy   <= 1'b0;
          r_rr_ptr <= r_ch_id;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_gnt       <= '0;
          r_ch_id     <= '0;
          r_dma_start <= 1'b0;
          r_busy      <= 1'b0;
          r_timeout   <= 1'b0;
          r_wdog      <= '0;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.ch_id     = r_ch_id;
  assign bus.dma_start = r_dma_start;
  assign bus.busy      = r_busy;
  assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_dma_chan_arbiter.sv
// Directed bench for dma_chan_arbiter: a default instance and a TIMEOUT=4 instance for the watchdog cases.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_dma_chan_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dma_chan_arbiter_if #(.NCH(4), .IDW(2)) bus ();
  dma_chan_arbiter_if #(.NCH(4), .IDW(2)) bus_wd ();

  dma_chan_arbiter #(.NCH(4), .IDW(2), .TIMEOUT(255), .TW(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dma_chan_arbiter #(.NCH(4), .IDW(2), .TIMEOUT(4), .TW(3)) u_dut_wd (
    .clk (clk),
    .rst (rst),
    .bus (bus_wd)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
  endtask

  // One full transfer on the default instance, starting in IDLE with the winner already eligible.
  // Done is sampled dd cycles after dma_start becomes visible.
  task automatic xfer(input int exp_ch, input int dd, input logic [3:0] req_after,
                      input logic [3:0] mask_after, input bit done_in_start);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0001 << exp_ch;
    tick();
    chk($sformatf("gnt_ch%0d", exp_ch), 32'(bus.gnt), 32'(exp_gnt));
    chk($sformatf("ch_id_ch%0d", exp_ch), 32'(bus.ch_id), 32'(exp_ch));
    chk("busy_at_grant", 32'(bus.busy), 32'd1);
    chk("no_start_at_grant", 32'(bus.dma_start), 32'd0);
    bus.req     = req_after;
    bus.ch_mask = mask_after;
    if (done_in_start) bus.dma_done = 1'b1;
    tick();
    bus.dma_done = 1'b0;
    chk("dma_start_pulse", 32'(bus.dma_start), 32'd1);
    tick(dd - 1);
    chk("busy_before_done", 32'(bus.busy), 32'd1);
    chk("start_is_one_cycle", 32'(bus.dma_start), 32'd0);
    bus.dma_done = 1'b1;
    tick();
    bus.dma_done = 1'b0;
    chk("gnt_held_in_release", 32'(bus.gnt), 32'(exp_gnt));
    tick();
    chk("gnt_cleared", 32'(bus.gnt), 32'd0);
    chk("busy_cleared", 32'(bus.busy), 32'd0);
    chk("ch_id_held", 32'(bus.ch_id), 32'(exp_ch));
    chk("no_timeout", 32'(bus.timeout), 32'd0);
  endtask

  initial begin
    bus.req        = '0;
    bus.ch_mask    = '0;
    bus.dma_done   = 1'b0;
    bus_wd.req      = '0;
    bus_wd.ch_mask  = '0;
    bus_wd.dma_done = 1'b0;

    // Reset state
    tick(2);
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ch_id", 32'(bus.ch_id), 32'd0);
    chk("rst_start", 32'(bus.dma_start), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_wd_gnt", 32'(bus_wd.gnt), 32'd0);
    rst = 1'b1;

    // 1: single requester; done during START is ignored; req dropped mid-transfer does not abort
    bus.req = 4'b0001;
    xfer(0, 5, 4'b0000, 4'b0000, 1'b1);
    tick();
    chk("t1_no_regrant", 32'(bus.gnt), 32'd0);
    chk("t1_ch_id_status", 32'(bus.ch_id), 32'd0);

    // 2: all requesting, order 0,1,2,3,0 from reset
    do_reset();
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) xfer(k % 4, 3, 4'b1111, 4'b0000, 1'b0);
    bus.req = 4'b0000;
    tick();
    chk("t2_idle", 32'(bus.gnt), 32'd0);

    // 3: ch2 masked, then unmasked during ch0's transfer
    bus.req     = 4'b0101;
    bus.ch_mask = 4'b0100;
    xfer(0, 3, 4'b0101, 4'b0100, 1'b0);
    xfer(0, 3, 4'b0101, 4'b0000, 1'b0);
    xfer(2, 3, 4'b0000, 4'b0000, 1'b0);
    tick();
    chk("t3_idle", 32'(bus.gnt), 32'd0);

    // 4: watchdog expiry with TIMEOUT=4, then next requester served
    do_reset();
    bus_wd.req = 4'b0011;
    tick();
    chk("t4_gnt_ch0", 32'(bus_wd.gnt), 32'b0001);
    tick();
    chk("t4_start", 32'(bus_wd.dma_start), 32'd1);
    tick(3);
    chk("t4_no_timeout_early", 32'(bus_wd.timeout), 32'd0);
    tick();
    chk("t4_timeout_pulse", 32'(bus_wd.timeout), 32'd1);
    chk("t4_gnt_in_release", 32'(bus_wd.gnt), 32'b0001);
    tick();
    chk("t4_timeout_one_cycle", 32'(bus_wd.timeout), 32'd0);
    chk("t4_gnt_cleared", 32'(bus_wd.gnt), 32'd0);
    chk("t4_busy_cleared", 32'(bus_wd.busy), 32'd0);
    tick();
    chk("t4_next_gnt_ch1", 32'(bus_wd.gnt), 32'b0010);
    chk("t4_next_ch_id", 32'(bus_wd.ch_id), 32'd1);

    // 5: done on the expiry cycle wins
    bus_wd.req = 4'b0000;
    tick();
    chk("t5_start", 32'(bus_wd.dma_start), 32'd1);
    tick(3);
    bus_wd.dma_done = 1'b1;
    tick();
    bus_wd.dma_done = 1'b0;
    chk("t5_no_timeout", 32'(bus_wd.timeout), 32'd0);
    chk("t5_gnt_in_release", 32'(bus_wd.gnt), 32'b0010);
    tick();
    chk("t5_timeout_still_0", 32'(bus_wd.timeout), 32'd0);
    chk("t5_gnt_cleared", 32'(bus_wd.gnt), 32'd0);

    // 6: reset asserted while BUSY clears outputs immediately
    do_reset();
    bus.req = 4'b0010;
    tick();
    chk("t6_gnt_ch1", 32'(bus.gnt), 32'b0010);
    tick(2);
    chk("t6_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_async_gnt", 32'(bus.gnt), 32'd0);
    chk("t6_async_busy", 32'(bus.busy), 32'd0);
    chk("t6_async_ch_id", 32'(bus.ch_id), 32'd0);
    tick();
    chk("t6_no_start_in_rst", 32'(bus.dma_start), 32'd0);
    chk("t6_no_timeout_in_rst", 32'(bus.timeout), 32'd0);
    rst = 1'b1;
    tick();
    chk("t6_regrant", 32'(bus.gnt), 32'b0010);
    chk("t6_regrant_id", 32'(bus.ch_id), 32'd1);
    tick();
    chk("t6_restart", 32'(bus.dma_start), 32'd1);
    bus.req = 4'b0000;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
